// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub
// Brief    : Bit-serial adder/subtractor. One result bit per clock, LSB
//            first, built from a single full-adder cell and a carry register.
//            Operands are captured on start, results are registered at the
//            completion edge and announced with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  // Operands are shifted right each bit so the full-adder always sees bit 0.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic s_bit;
  logic c_next;
  logic last_bit;
  logic capture;

  // Single full-adder cell and control decodes.
  always_comb begin
    s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    last_bit = (cnt == LAST);
    capture  = (state == IDLE) && start;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; busy and done are pure decodes of the state.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Serial datapath: capture operands, then one bit per RUN cycle; the
  // visible result registers only change on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (capture) begin
      a_sh  <= a;
      b_sh  <= sub ? ~b : b;
      carry <= sub | cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= c_next;
      res   <= {s_bit, res[WIDTH-1:1]};
      cnt   <= last_bit ? '0 : cnt + CW'(1);
      if (last_bit) begin
        sum      <= {s_bit, res[WIDTH-1:1]};
        cout     <= c_next;
        // carry currently holds the carry into the MSB.
        overflow <= carry ^ c_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub
// Brief    : Scoreboard bench for serial_addsub at WIDTH=8 and WIDTH=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q2[$];

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .overflow(ovf8)
  );

  serial_addsub #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2),
    .overflow(ovf2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: unsigned sum for {cout,sum}; exact signed arithmetic for overflow.
  function automatic exp_t model(input int w, input logic [7:0] a,
                                 input logic [7:0] b, input bit sub,
                                 input bit cin, input int dcyc);
    exp_t   r;
    longint mask  = (longint'(1) << w) - 1;
    longint half  = longint'(1) << (w - 1);
    longint ua    = longint'(a) & mask;
    longint ub    = longint'(b) & mask;
    longint bp    = sub ? (~ub & mask) : ub;
    longint tot   = ua + bp + (sub ? 1 : longint'(cin));
    longint sa    = (ua >= half) ? ua - (mask + 1) : ua;
    longint sb    = (ub >= half) ? ub - (mask + 1) : ub;
    longint ideal = sub ? (sa - sb) : (sa + sb + longint'(cin));
    r.sum  = 8'(tot & mask);
    r.cout = ((tot >> w) & 1) != 0;
    r.ovf  = (ideal > half - 1) || (ideal < -half);
    r.cyc  = dcyc;
    return r;
  endfunction

  // Monitor for WIDTH=8: holds outputs steady during RUN, checks each done.
  logic [7:0] ls8 = '0;
  logic       lc8 = 1'b0, lo8 = 1'b0;
  int         bc8 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ls8 = '0; lc8 = 1'b0; lo8 = 1'b0; bc8 = 0;
    end else begin
      if (busy8) begin
        bc8++;
        check("hold8", {cout8, ovf8, sum8}, {lc8, lo8, ls8});
      end
      if (done8) begin
        if (q8.size() == 0) begin
          check("unexpected_done8", 1, 0);
        end else begin
          e = q8.pop_front();
          check("sum8", sum8, e.sum);
          check("cout8", cout8, e.cout);
          check("ovf8", ovf8, e.ovf);
          check("latency8", cyc, e.cyc);
          check("busy_len8", bc8, 8);
          ls8 = e.sum; lc8 = e.cout; lo8 = e.ovf;
        end
        bc8 = 0;
      end
    end
  end

  // Monitor for WIDTH=2.
  logic [1:0] ls2 = '0;
  logic       lc2 = 1'b0, lo2 = 1'b0;
  int         bc2 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ls2 = '0; lc2 = 1'b0; lo2 = 1'b0; bc2 = 0;
    end else begin
      if (busy2) begin
        bc2++;
        check("hold2", {cout2, ovf2, sum2}, {lc2, lo2, ls2});
      end
      if (done2) begin
        if (q2.size() == 0) begin
          check("unexpected_done2", 1, 0);
        end else begin
          e = q2.pop_front();
          check("sum2", sum2, e.sum[1:0]);
          check("cout2", cout2, e.cout);
          check("ovf2", ovf2, e.ovf);
          check("spacing2", cyc, e.cyc);
          check("busy_len2", bc2, 2);
          ls2 = e.sum[1:0]; lc2 = e.cout; lo2 = e.ovf;
        end
        bc2 = 0;
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the capture edge.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input bit sub, input bit cin);
    int t = 0;
    while ((busy8 || done8) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("idle_wait8", t >= 50, 0);
    a8 = a; b8 = b; sub8 = sub; cin8 = cin; start8 = 1'b1;
    @(posedge clk); #1;
    q8.push_back(model(8, a, b, sub, cin, cyc + 8));
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((q8.size() != 0 || q2.size() != 0) && t < 200) begin
      @(posedge clk); t++;
    end
    #1;
    check("drain_timeout", t >= 200, 0);
  endtask

  task automatic set2(input int i);
    a2 = 2'(i); b2 = 2'(i >> 2); cin2 = 1'((i >> 4)); sub2 = 1'((i >> 5));
  endtask

  initial begin
    logic [1:0] ca, cb;
    logic       cc, cs;
    // Reset state
    #3;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_out8", {cout8, ovf8, sum8}, 0);
    check("rst_out2", {busy2, done2, cout2, ovf2, sum2}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors
    run8(8'h0F, 8'h01, 0, 0);
    run8(8'hFF, 8'h01, 0, 0);
    run8(8'h7F, 8'h00, 0, 1);
    run8(8'h05, 8'h07, 1, 0);
    run8(8'h80, 8'h01, 1, 1);
    run8(8'h00, 8'h80, 1, 0);
    drain();

    // start during RUN must be ignored
    run8(8'h3C, 8'h15, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    drain();

    // Reset in the middle of RUN
    run8(8'h12, 8'h34, 0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    q8.delete();
    #1;
    check("midrst_busy8", busy8, 0);
    check("midrst_out8", {done8, cout8, ovf8, sum8}, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_done8", done8, 0);
    end
    rst = 1'b0;
    run8(8'h01, 8'h01, 0, 0);
    drain();

    // Randomized operations with random idle gaps
    for (int k = 0; k < 40; k++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if (($urandom & 3) == 0) drain();
    end
    drain();

    // Exhaustive WIDTH=2 back-to-back with start held high
    set2(0);
    start2 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ca = a2; cb = b2; cc = cin2; cs = sub2;
      @(posedge clk); #1;
      q2.push_back(model(2, {6'd0, ca}, {6'd0, cb}, cs, cc, cyc + 2));
      if (i < 63) set2(i + 1);
      else start2 = 1'b0;
      repeat (3) @(posedge clk);
    end
    drain();
    repeat (4) @(posedge clk);
    #1;
    check("final_idle", {busy8, done8, busy2, done2}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
